// File: rtl/vote_tally_multi_if.sv
// Button-side and display-side signals of the multi-candidate vote tally.
interface vote_tally_multi_if #(
  parameter int unsigned NUM_CAND = 3,
  parameter int unsigned CNT_W    = 8
);
  localparam int unsigned LeadW = $clog2(NUM_CAND);

  logic                mode;
  logic [NUM_CAND-1:0] button;
  logic [CNT_W-1:0]    led;
  logic                vote_valid;
  logic                invalid_press;
  logic [LeadW-1:0]    leader;
  logic                tie;

  // Button logic / display driver side.
  modport master (
    output mode, button,
    input  led, vote_valid, invalid_press, leader, tie
  );

  // Tally side.
  modport slave (
    input  mode, button,
    output led, vote_valid, invalid_press, leader, tie
  );
endinterface

// File: rtl/vote_tally_multi.sv
// Multi-candidate vote tally: hold-qualified single-button votes, one vote per
// press, multi-press rejection, saturating counters, leader/tie and display.
module vote_tally_multi #(
  parameter int unsigned NUM_CAND    = 3,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  vote_tally_multi_if.slave    bus
);
  localparam int unsigned LeadW = $clog2(NUM_CAND);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StArming, StWaitRelease} state_e;

  state_e              state_q, state_d;
  logic [LeadW-1:0]    idx_q, idx_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0]    count_q [NUM_CAND];
  logic [CNT_W-1:0]    count_d [NUM_CAND];
  logic [CNT_W-1:0]    led_q, led_d;
  logic                vote_valid_q, vote_valid_d;
  logic                invalid_press_q, invalid_press_d;

  logic                btn_any, btn_one, other_high;
  logic [LeadW-1:0]    btn_idx;
  logic [NUM_CAND-1:0] idx_mask;
  logic [CNT_W-1:0]    max_cnt;
  logic [LeadW-1:0]    lead;
  logic [4:0]          n_max;
  logic                tie;
  logic                vote;
  logic [LeadW-1:0]    vote_idx;

  // Button decode: any/one-hot, index of the pressed button, and whether any
  // button other than the armed one is high.
  always_comb begin
    btn_any  = |bus.button;
    btn_one  = btn_any &&
               ((bus.button & (bus.button - {{(NUM_CAND-1){1'b0}}, 1'b1})) == '0);
    btn_idx  = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (bus.button[i]) btn_idx = LeadW'(i);
    end
    idx_mask   = {{(NUM_CAND-1){1'b0}}, 1'b1} << idx_q;
    other_high = |(bus.button & ~idx_mask);
  end

  // Leader is the lowest index holding the maximum; tie needs >=2 at a nonzero max.
  always_comb begin
    max_cnt = '0;
    lead    = '0;
    n_max   = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (count_q[i] > max_cnt) begin
        max_cnt = count_q[i];
        lead    = LeadW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (count_q[i] == max_cnt) n_max = n_max + 5'd1;
    end
    tie = (n_max >= 5'd2) && (max_cnt != '0);
  end

  // Vote FSM next state, saturating count update and display value.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    hold_d          = hold_q;
    count_d         = count_q;
    vote_valid_d    = 1'b0;
    invalid_press_d = 1'b0;
    vote            = 1'b0;
    vote_idx        = idx_q;

    unique case (state_q)
      StIdle: begin
        if (!bus.mode && btn_any) begin
          if (btn_one) begin
            idx_d = btn_idx;
            if (HOLD_CYCLES == 1) begin
              vote     = 1'b1;
              vote_idx = btn_idx;
              state_d  = StWaitRelease;
              hold_d   = '0;
            end else begin
              state_d = StArming;
              hold_d  = HoldW'(1);
            end
          end else begin
            invalid_press_d = 1'b1;
            state_d         = StWaitRelease;
          end
        end
      end
      StArming: begin
        if (!btn_any) begin
          state_d = StIdle;
          hold_d  = '0;
        end else if (bus.mode) begin
          // Switching to display aborts the pending vote.
          state_d = StWaitRelease;
          hold_d  = '0;
        end else if (other_high) begin
          invalid_press_d = 1'b1;
          state_d         = StWaitRelease;
          hold_d          = '0;
        end else if (hold_q == HoldW'(HOLD_CYCLES - 1)) begin
          vote    = 1'b1;
          state_d = StWaitRelease;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StWaitRelease: begin
        if (!btn_any) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (vote) begin
      vote_valid_d = 1'b1;
      if (count_q[vote_idx] != '1) count_d[vote_idx] = count_q[vote_idx] + CNT_W'(1);
    end

    if (!bus.mode) begin
      led_d = '0;
    end else if (btn_one) begin
      led_d = count_q[btn_idx];
    end else if (!btn_any) begin
      led_d = CNT_W'(lead);
    end else begin
      led_d = led_q;
    end
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      hold_q          <= '0;
      led_q           <= '0;
      vote_valid_q    <= 1'b0;
      invalid_press_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CAND; i++) count_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      hold_q          <= hold_d;
      led_q           <= led_d;
      vote_valid_q    <= vote_valid_d;
      invalid_press_q <= invalid_press_d;
      for (int unsigned i = 0; i < NUM_CAND; i++) count_q[i] <= count_d[i];
    end
  end

  assign bus.led           = led_q;
  assign bus.vote_valid    = vote_valid_q;
  assign bus.invalid_press = invalid_press_q;
  assign bus.leader        = lead;
  assign bus.tie           = tie;
endmodule

// File: tb/tb_vote_tally_multi.sv
// Scoreboard bench for vote_tally_multi: a press-run reference model queues the
// expected post-edge outputs, a monitor pops and compares one record per edge.
module tb_vote_tally_multi;
  localparam int unsigned NC = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned HC = 10;
  localparam int unsigned LW = $clog2(NC);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  vote_tally_multi_if #(.NUM_CAND(NC), .CNT_W(CW)) bus ();

  vote_tally_multi #(.NUM_CAND(NC), .CNT_W(CW), .HOLD_CYCLES(HC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int vv;
    int ip;
    int led;
    int leader;
    int tie;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: counts, length of the current clean single-button run,
  // and whether the current press has already been used up.
  int   m_cnt[NC];
  int   m_streak;
  int   m_cand;
  bit   m_spent;
  int   m_led;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void ref_leader(output int lead, output int tie);
    int maxv = 0;
    int nmax = 0;
    for (int i = 0; i < NC; i++) if (m_cnt[i] > maxv) maxv = m_cnt[i];
    lead = 0;
    for (int i = NC - 1; i >= 0; i--) if (m_cnt[i] == maxv) lead = i;
    for (int i = 0; i < NC; i++) if (m_cnt[i] == maxv) nmax++;
    tie = (nmax >= 2 && maxv > 0) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) m_cnt[i] = 0;
    m_streak = 0;
    m_cand   = 0;
    m_spent  = 1'b0;
    m_led    = 0;
  endfunction

  task automatic model_step(input logic md, input logic [NC-1:0] b);
    exp_t e;
    int   pc;
    int   c;
    int   ld;
    int   tq;
    pc = $countones(b);
    c  = 0;
    for (int i = 0; i < NC; i++) if (b[i]) c = i;
    e.vv = 0;
    e.ip = 0;
    // Display reflects counts before this edge (no counting happens in mode 1).
    ref_leader(ld, tq);
    if (md) begin
      if (pc == 0) m_led = ld;
      else if (pc == 1) m_led = m_cnt[c];
    end else begin
      m_led = 0;
    end
    if (pc == 0) begin
      m_spent  = 1'b0;
      m_streak = 0;
    end else if (m_spent) begin
      m_streak = 0;
    end else if (md) begin
      if (m_streak > 0) m_spent = 1'b1;
      m_streak = 0;
    end else if (pc > 1 || (m_streak > 0 && c != m_cand)) begin
      e.ip     = 1;
      m_spent  = 1'b1;
      m_streak = 0;
    end else begin
      m_cand   = c;
      m_streak = m_streak + 1;
      if (m_streak == HC) begin
        e.vv = 1;
        if (m_cnt[c] < (2 ** CW) - 1) m_cnt[c] = m_cnt[c] + 1;
        m_spent  = 1'b1;
        m_streak = 0;
      end
    end
    ref_leader(ld, tq);
    e.led    = m_led;
    e.leader = ld;
    e.tie    = tq;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs; records are pushed after the monitor's sample point.
  task automatic step(input logic md, input logic [NC-1:0] b);
    bus.mode   = md;
    bus.button = b;
    model_step(md, b);
    @(posedge clock);
    #3;
  endtask

  task automatic vote(input int c);
    logic [NC-1:0] b;
    b = '0;
    b[c] = 1'b1;
    repeat (HC) step(1'b0, b);
    step(1'b0, '0);
  endtask

  task automatic do_reset();
    int ld;
    int tq;
    #1 reset = 1'b1;
    #1;
    model_reset();
    ref_leader(ld, tq);
    check("rst_led", int'(bus.led), m_led);
    check("rst_vote_valid", int'(bus.vote_valid), 0);
    check("rst_invalid", int'(bus.invalid_press), 0);
    check("rst_leader", int'(bus.leader), ld);
    check("rst_tie", int'(bus.tie), tq);
    check("rst_queue", sb.size(), 0);
    #1 reset = 1'b0;
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("vote_valid", int'(bus.vote_valid), e.vv);
        check("invalid_press", int'(bus.invalid_press), e.ip);
        check("led", int'(bus.led), e.led);
        check("leader", int'(bus.leader), e.leader);
        check("tie", int'(bus.tie), e.tie);
      end
    end
  end

  initial begin
    logic          md;
    logic [NC-1:0] b;
    logic [NC-1:0] b2;
    int            len;
    model_reset();
    reset      = 1'b1;
    bus.mode   = 1'b0;
    bus.button = '0;
    #12;
    check("init_led", int'(bus.led), 0);
    check("init_vote_valid", int'(bus.vote_valid), 0);
    check("init_invalid", int'(bus.invalid_press), 0);
    check("init_leader", int'(bus.leader), 0);
    check("init_tie", int'(bus.tie), 0);
    reset = 1'b0;
    @(posedge clock);
    #3;

    // Long hold counts once, then display candidate 0.
    repeat (40) step(1'b0, 3'b001);
    step(1'b0, '0);
    step(1'b1, 3'b001);
    step(1'b1, '0);
    step(1'b0, '0);
    // Early release, then a full hold.
    repeat (6) step(1'b0, 3'b010);
    step(1'b0, '0);
    vote(1);
    // Two buttons together are rejected once.
    repeat (20) step(1'b0, 3'b110);
    step(1'b0, '0);
    vote(2);
    // Leader and tie movement.
    vote(0);
    vote(2);
    vote(0);
    step(1'b1, '0);
    vote(2);
    step(1'b1, '0);
    step(1'b1, 3'b011);
    step(1'b1, 3'b100);
    step(1'b0, '0);
    // Display mode aborts an armed vote; the held button stays spent.
    repeat (5) step(1'b0, 3'b001);
    repeat (3) step(1'b1, 3'b001);
    repeat (12) step(1'b0, 3'b001);
    step(1'b0, '0);
    // HOLD-1 then switch to another button: rejected.
    repeat (HC - 1) step(1'b0, 3'b100);
    repeat (3) step(1'b0, 3'b010);
    step(1'b0, '0);

    // Randomized presses.
    for (int k = 0; k < 150; k++) begin
      md  = ($urandom_range(0, 7) == 0);
      b   = NC'($urandom_range(0, 7));
      len = $urandom_range(1, 14);
      repeat (len) step(md, b);
      if ($urandom_range(0, 3) == 0) begin
        b2 = NC'($urandom_range(1, 7));
        repeat ($urandom_range(1, 4)) step(1'b0, b2);
      end
      repeat ($urandom_range(0, 2)) step(1'b0, '0);
    end
    step(1'b0, '0);

    // Saturation of candidate 1.
    repeat (260) vote(1);
    step(1'b1, 3'b010);
    step(1'b1, '0);
    step(1'b0, '0);

    // Reset in the middle of arming after votes exist.
    repeat (5) step(1'b0, 3'b001);
    do_reset();
    step(1'b0, '0);
    vote(2);
    step(1'b1, '0);
    step(1'b0, '0);
    step(1'b0, '0);
    check("queue_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/vote_tally_multi.md
Name: vote_tally_multi

Overview:
Parametrised multi-candidate voting tally, the next generation of the three-button voting machine. It counts votes for NUM_CAND candidates with a hold-time qualifier, a one-vote-per-press rule and multi-press rejection. Counters saturate instead of wrapping. In display mode it shows a selected candidate's count, or the current leader when no button is held. It sits between the button input logic and the LED display driver.

Parameters:
NUM_CAND, 3, number of candidates and width of the button bus (2..16)
CNT_W, 8, width of each vote counter and of led
HOLD_CYCLES, 10, consecutive cycles a single button must be held before a vote registers (>=1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
mode  input  1  0 = vote, 1 = display
button  input  NUM_CAND  one bit per candidate, active-high, synchronous to clock (no synchronizer inside)
led  output  CNT_W  registered display value
vote_valid  output  1  one-cycle pulse when a vote is counted
invalid_press  output  1  one-cycle pulse when more than one button is high in vote mode
leader  output  $clog2(NUM_CAND)  index of the leading candidate
tie  output  1  more than one candidate shares the max count, and max > 0

Behaviour:
- Reset (async): all counts 0, FSM IDLE, hold counter 0, led 0, vote_valid 0, invalid_press 0; leader 0, tie 0 (derived).
- Vote FSM (mode=0), states IDLE, ARMING, WAIT_RELEASE:
  - IDLE: exactly one button high -> ARMING, latch index, hold counter = 1. More than one high -> invalid_press pulse, -> WAIT_RELEASE. None -> stay.
  - ARMING: same single button still high -> hold counter +1. When hold counter reaches HOLD_CYCLES, on that edge: count[idx] += 1 (saturating at 2^CNT_W-1), vote_valid = 1 for one cycle, -> WAIT_RELEASE. Button released early -> IDLE, no vote. Any other button also high -> invalid_press pulse, -> WAIT_RELEASE, no vote.
  - WAIT_RELEASE: stay until all buttons low, then -> IDLE. A held button never produces a second vote.
- Vote latency: if a single button is first sampled high at edge k, the count updates and vote_valid asserts at edge k+HOLD_CYCLES-1. HOLD_CYCLES=1 counts on the first sampling edge.
- Saturation: a vote for a saturated counter still pulses vote_valid and leaves the count unchanged.
- mode=1 (any state): no counting, no invalid_press. An FSM in ARMING goes to WAIT_RELEASE (vote aborted). IDLE stays IDLE.
- Display (registered, 1-cycle latency): mode=1 with exactly one button high -> led = count[that index]. mode=1 with no button -> led = leader index zero-extended. mode=1 with several buttons -> led holds its previous value. mode=0 -> led = 0.
- leader/tie: combinational from the count registers. leader is the lowest index holding the max count. tie = 1 only when at least 2 counts equal the max and max != 0.
- reset mid-ARMING: vote discarded, all counts 0 immediately.

Test Plan:
- Defaults; reset, then button=3'b001 held 10 cycles -> count0=1, vote_valid one pulse on the 10th sampled edge; keep holding 30 more cycles -> no further vote; release, mode=1, button=001 -> led=1 one cycle later.
- button=3'b010 held 6 cycles then released -> no vote_valid, count1=0; then held 10 cycles -> count1=1.
- button=3'b110 for 20 cycles -> invalid_press exactly one pulse, no counts change; release, then button=100 held 10 -> count2=1.
- Cast 2 votes for candidate 0 and 2 for candidate 2 -> tie=1, leader=0; one more for candidate 2 -> tie=0, leader=2; mode=1 with no button -> led=2.
- CNT_W=2: cast 5 votes for candidate 1 -> count1=3, five vote_valid pulses, led=3 in display.
- Hold button=001 for 5 cycles, then mode=1 -> no vote; assert reset mid-ARMING after prior votes -> all counts 0, led=0, leader=0, tie=0 asynchronously.
